// File: rtl/lift_pkg.sv
// Shared lift types and defaults: state encoding, direction encoding, floor-index width helper.
// Also used by the floor request manager, so keep it free of controller-specific logic.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } lift_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int LIFT_NUM_FLOORS    = 3;
    localparam int LIFT_TRAVEL_CYCLES = 8;
    localparam int LIFT_DOOR_CYCLES   = 16;

    // Width of an index able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lift_dwell_timer.sv
// Loadable down counter with hold; load wins over hold, and the count rests at zero.
// One instance times floor travel, the other times door dwell.
module lift_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_hold,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (!i_hold && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/lift_car_controller.sv
// SCAN car sequencer: moves toward live targets, keeps direction while targets remain ahead,
// times travel and door dwell, and reports a one-hot position back to the request manager.
module lift_car_controller
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS    = LIFT_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = LIFT_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = LIFT_DOOR_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_floor,
    input  logic                  start,
    input  logic                  door_hold,
    input  logic                  estop,
    output logic [NUM_FLOORS-1:0] current_floor,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  arrived
);

    localparam int IDX_W = idx_width(NUM_FLOORS);
    localparam int TRV_W = idx_width(TRAVEL_CYCLES);
    localparam int DR_W  = idx_width(DOOR_CYCLES);

    localparam logic [TRV_W-1:0] TRV_RELOAD = TRV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DR_W-1:0]  DR_RELOAD  = DR_W'(DOOR_CYCLES - 1);

    lift_state_t      r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_dir;
    logic             r_arrived;

    logic [NUM_FLOORS-1:0] w_tgt;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_cur_here, w_cur_above, w_cur_below;
    logic                  w_nxt_here, w_nxt_above, w_nxt_below;
    logic                  w_nxt_ahead, w_nxt_behind;
    logic                  w_step;
    logic                  w_trv_load, w_trv_zero;
    logic                  w_door_load, w_door_zero;

    // Returns {here, above, below} for target mask t seen from floor idx.
    function automatic logic [2:0] scan_flags(input logic [NUM_FLOORS-1:0] t,
                                              input logic [IDX_W-1:0] idx);
        logic h, a, b;
        h = 1'b0;
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (t[i]) begin
                if (i > int'(idx))      a = 1'b1;
                else if (i < int'(idx)) b = 1'b1;
                else                    h = 1'b1;
            end
        end
        return {h, a, b};
    endfunction

    assign w_tgt      = start ? req_floor : '0;
    assign w_next_idx = (r_dir == DIR_UP) ? (r_idx + 1'b1) : (r_idx - 1'b1);

    assign {w_cur_here, w_cur_above, w_cur_below} = scan_flags(w_tgt, r_idx);
    assign {w_nxt_here, w_nxt_above, w_nxt_below} = scan_flags(w_tgt, w_next_idx);

    // Targets relative to the floor the car is about to reach, split by current direction.
    assign w_nxt_ahead  = (r_dir == DIR_UP) ? w_nxt_above : w_nxt_below;
    assign w_nxt_behind = (r_dir == DIR_UP) ? w_nxt_below : w_nxt_above;
    assign w_step       = (r_state == MOVING) && !estop && w_trv_zero;

    assign w_trv_load = ((r_state == IDLE) && !estop && !w_cur_here && (w_cur_above || w_cur_below))
                     || (w_step && !w_nxt_here && (w_nxt_above || w_nxt_below));

    assign w_door_load = ((r_state == IDLE) && !estop && w_cur_here)
                      || (w_step && w_nxt_here)
                      || ((r_state == DOOR_OPEN) && !estop && door_hold);

    lift_dwell_timer #(.W(TRV_W)) u_travel_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_trv_load),
        .i_load_val (TRV_RELOAD),
        .i_hold     (estop),
        .o_zero     (w_trv_zero)
    );

    lift_dwell_timer #(.W(DR_W)) u_door_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_door_load),
        .i_load_val (DR_RELOAD),
        .i_hold     (estop),
        .o_zero     (w_door_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_dir     <= DIR_UP;
            r_arrived <= 1'b0;
        end else begin
            r_arrived <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!estop) begin
                        if (w_cur_here) begin
                            r_state   <= DOOR_OPEN;
                            r_arrived <= 1'b1;
                        end else if (w_cur_above) begin
                            r_state <= MOVING;
                            r_dir   <= DIR_UP;
                        end else if (w_cur_below) begin
                            r_state <= MOVING;
                            r_dir   <= DIR_DOWN;
                        end
                    end
                end
                MOVING: begin
                    if (w_step) begin
                        r_idx <= w_next_idx;
                        if (w_nxt_here) begin
                            r_state   <= DOOR_OPEN;
                            r_arrived <= 1'b1;
                        end else if (w_nxt_ahead) begin
                            r_state <= MOVING;
                        end else if (w_nxt_behind) begin
                            r_dir <= ~r_dir;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (!estop && !door_hold && w_door_zero) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign current_floor = NUM_FLOORS'(1) << r_idx;
    assign motor_up      = (r_state == MOVING) && (r_dir == DIR_UP)   && !estop;
    assign motor_down    = (r_state == MOVING) && (r_dir == DIR_DOWN) && !estop;
    assign door_open     = (r_state == DOOR_OPEN);
    assign arrived       = r_arrived;

endmodule

// File: tb/tb_lift_car_controller.sv
// Directed bench for lift_car_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=6, three floors.
module tb_lift_car_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_floor;
    logic       start;
    logic       door_hold;
    logic       estop;
    logic [2:0] current_floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       arrived;

    int n_tests = 0;
    int n_fail  = 0;

    lift_car_controller #(
        .NUM_FLOORS    (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_floor     (req_floor),
        .start         (start),
        .door_hold     (door_hold),
        .estop         (estop),
        .current_floor (current_floor),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .arrived       (arrived)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic       st;
        int         n;
        logic [2:0] floor;
        logic       up;
        logic       down;
        logic       door;
        logic       arr;
    } vec_t;

    vec_t tbl[11];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] fl, input logic up,
                           input logic dn, input logic dr, input logic ar);
        chk({name, ".floor"},   32'(current_floor), 32'(fl));
        chk({name, ".up"},      32'(motor_up),      32'(up));
        chk({name, ".down"},    32'(motor_down),    32'(dn));
        chk({name, ".door"},    32'(door_open),     32'(dr));
        chk({name, ".arrived"}, 32'(arrived),       32'(ar));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Up to floor 2, then back down to floor 0; requests cleared while the door is open.
        tbl[0]  = '{3'b100, 1'b1, 1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'b100, 1'b1, 3, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'b100, 1'b1, 1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'b100, 1'b1, 4, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{3'b000, 1'b1, 1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'b000, 1'b1, 4, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'b000, 1'b1, 1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'b001, 1'b1, 1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{3'b001, 1'b1, 4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{3'b001, 1'b1, 4, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{3'b000, 1'b1, 6, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_floor = 3'b000;
        start     = 1'b0;
        door_hold = 1'b0;
        estop     = 1'b0;
        tick(3);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_all("reset_idle", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 11; i++) begin
            req_floor = tbl[i].req;
            start     = tbl[i].st;
            tick(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].floor, tbl[i].up, tbl[i].down,
                    tbl[i].door, tbl[i].arr);
        end

        // Direction reversal: new target at floor 0 appears while heading up to floor 2.
        req_floor = 3'b100;
        start     = 1'b1;
        tick(5);
        chk_all("rev_pass1", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        req_floor = 3'b101;
        tick(4);
        chk_all("rev_arr2", 3'b100, 1'b0, 1'b0, 1'b1, 1'b1);
        req_floor = 3'b001;
        tick(6);
        chk_all("rev_closed", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("rev_down", 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk_all("rev_pass1d", 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk_all("rev_arr0", 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
        req_floor = 3'b000;
        tick(6);
        chk_all("rev_idle", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Emergency stop mid-segment freezes the travel count.
        req_floor = 3'b010;
        tick(3);
        estop = 1'b1;
        #1;
        chk_all("estop_drop", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("estop_hold.floor", 32'(current_floor), 32'(3'b001));
            chk("estop_hold.up",    32'(motor_up),      32'(1'b0));
        end
        estop = 1'b0;
        #1;
        chk_all("estop_rel", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("estop_last", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("estop_arr", 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
        req_floor = 3'b000;
        tick(6);
        chk_all("estop_idle", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset returns the car to floor 0, then start drops mid-segment.
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        rst_n     = 1'b1;
        req_floor = 3'b010;
        start     = 1'b1;
        tick(3);
        start = 1'b0;
        tick(1);
        chk_all("drop_seg", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("drop_end", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_all("drop_idle", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Door hold pulses keep the door open; it closes 6 cycles after the last pulse.
        req_floor = 3'b010;
        start     = 1'b1;
        tick(1);
        chk_all("hold_open", 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
        req_floor = 3'b000;
        start     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            door_hold = 1'b1;
            tick(1);
            door_hold = 1'b0;
            chk("hold_pulse.door", 32'(door_open), 32'(1'b1));
            for (int j = 0; j < 3; j++) begin
                tick(1);
                chk("hold_gap.door", 32'(door_open), 32'(1'b1));
            end
        end
        tick(2);
        chk("hold_tail.door", 32'(door_open), 32'(1'b1));
        tick(1);
        chk_all("hold_close", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
